// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single 4-bit slice.
// Optional `ADDSUB_ZERO_FLAG_EN adds a registered zero-result flag output.
module nibble_serial_addsub_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef ADDSUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             overflow
);

    // state | meaning
    // IDLE  | waiting for an operand set, in_ready high
    // RUN   | one nibble per cycle through the slice, LSB first
    // DONE  | result held with out_valid high until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_m;
    logic               r_carry;
    logic [3:0]         r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;

    logic [5:0]         w_idx;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_x;
    logic [4:0]         w_sum;
    logic               w_last;
    logic               w_accept;

    assign w_idx    = {r_cnt, 2'b00};
    assign w_a_nib  = r_a[w_idx +: 4];
    assign w_b_x    = r_b[w_idx +: 4] ^ {4{r_m}};
    assign w_sum    = {1'b0, w_a_nib} + {1'b0, w_b_x} + {4'b0000, r_carry};
    assign w_last   = (r_cnt == 4'(NIBBLES - 1));
    assign w_accept = (r_state == IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            // subtract is A + ~B + 1, so the mode bit seeds the carry
            r_a     <= op_a;
            r_b     <= op_b;
            r_m     <= op_m;
            r_carry <= op_m;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_result[w_idx +: 4] <= w_sum[3:0];
            r_carry              <= w_sum[4];
            r_cnt                <= r_cnt + 4'd1;
            if (w_last) begin
                r_cout <= w_sum[4];
                r_ovf  <= (w_a_nib[3] == w_b_x[3]) && (w_sum[3] != w_a_nib[3]);
            end
        end
    end

`ifdef ADDSUB_ZERO_FLAG_EN
    logic r_nz;
    logic r_zero;
    logic w_nz_nxt;

    assign w_nz_nxt = r_nz | (w_sum[3:0] != 4'h0);

    // sticky "any nonzero nibble" collapses into the zero flag on the last nibble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nz   <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_nz <= 1'b0;
        end else if (r_state == RUN) begin
            r_nz <= w_nz_nxt;
            if (w_last) begin
                r_zero <= ~w_nz_nxt;
            end
        end
    end

    assign zero = r_zero;
`endif

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Self-checking bench for nibble_serial_addsub_ctrl: directed corners plus random operations
// compared against an arithmetic reference model.
module tb_nibble_serial_addsub_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_m;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          cout;
    logic          overflow;
`ifdef ADDSUB_ZERO_FLAG_EN
    logic          zero;
`endif

    int n_checks = 0;
    int n_err    = 0;

    nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_m      (op_m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
`ifdef ADDSUB_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                  output logic [W-1:0] r, output logic c, output logic v);
        longint ua, ub, sa, sb, st, full;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= (64'sd1 <<< (W - 1))) ? ua - (64'sd1 <<< W) : ua;
        sb = (ub >= (64'sd1 <<< (W - 1))) ? ub - (64'sd1 <<< W) : ub;
        if (m) begin
            r  = a - b;
            c  = (ua >= ub);
            st = sa - sb;
        end else begin
            full = ua + ub;
            r    = a + b;
            c    = (full >= (64'sd1 <<< W));
            st   = sa + sb;
        end
        v = (st > (64'sd1 <<< (W - 1)) - 1) || (st < -(64'sd1 <<< (W - 1)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full transaction; hold = DONE cycles with out_ready low,
    // disturb = drive junk operands with in_valid high during RUN.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input int hold, input bit disturb);
        logic [W-1:0] er;
        logic         ec, ev;
        int           lat;
        model(a, b, m, er, ec, ev);
        check("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        op_m      = m;
        out_ready = 1'b0;
        tick();
        in_valid = disturb;
        op_a     = disturb ? '1 : W'($urandom);
        op_b     = W'($urandom);
        op_m     = ~m;
        check("in_ready_in_run", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 4 * NIBBLES + 10) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, NIBBLES);
        check("result", result, er);
        check("cout", cout, ec);
        check("overflow", overflow, ev);
`ifdef ADDSUB_ZERO_FLAG_EN
        check("zero", zero, (er == '0));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            tick();
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", result, er);
            check("hold_cout", cout, ec);
            check("hold_overflow", overflow, ev);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        if (disturb) begin
            tick();
            check("single_txn_out_valid", out_valid, 0);
            check("single_txn_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_m      = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_overflow", overflow, 0);
`ifdef ADDSUB_ZERO_FLAG_EN
        check("rst_zero", zero, 0);
`endif

        do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
        do_op(16'h0002, 16'h0001, 1'b1, 0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b1, 0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b0, 5, 1'b0);
        do_op(16'h0F0F, 16'h0101, 1'b0, 0, 1'b1);

        // reset while RUN is on nibble 2
        check("mid_rst_in_ready", in_ready, 1);
        in_valid = 1'b1;
        op_a     = 16'h1234;
        op_b     = 16'h4321;
        op_m     = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready2", in_ready, 1);
        check("mid_rst_result", result, 0);
        check("mid_rst_cout", cout, 0);
        do_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
